// File: rtl/cl_cfg_reg_bank.sv
// Config-bus register bank: scratch/control, 64-bit cycle counter with snapshot, access counter,
// sticky W1C status. Optional countdown timer enabled by CL_CFG_REG_BANK_TIMER_EN.
module cl_cfg_reg_bank #(
  parameter int unsigned ACK_LAT = 1
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic [31:0] cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  input  logic        cfg_wr_i,
  input  logic        cfg_rd_i,
  output logic        cfg_ack_o,
  output logic [31:0] cfg_rdata_o,
  output logic [31:0] ctrl_out_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  localparam logic [5:0] AddrScratch = 6'h00;
  localparam logic [5:0] AddrCtrl    = 6'h01;
  localparam logic [5:0] AddrStatus  = 6'h02;
  localparam logic [5:0] AddrCntLo   = 6'h03;
  localparam logic [5:0] AddrCntHi   = 6'h04;
  localparam logic [5:0] AddrAccCnt  = 6'h05;
  localparam logic [5:0] AddrTmrLoad = 6'h06;
  localparam logic [5:0] AddrTmrCur  = 6'h07;
  localparam logic [1:0] WaitInit    = (ACK_LAT >= 2) ? 2'(ACK_LAT - 2) : 2'd0;

  state_e      state_q;
  logic [1:0]  wait_q;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic        ack_q;
  logic [31:0] rdata_q;

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [1:0]  status_q, status_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] acc_q, acc_d;
  logic        tmr_exp;

  logic        go_ack;
  logic [5:0]  rd_idx;
  logic        rd_is_wr;
  logic [31:0] rd_next;
  logic        do_acc;
  logic        do_wr;
  logic        cnt_clr;
  logic        cnt_wrap;
  logic        unused_addr;

  assign unused_addr = ^{cfg_addr_i[31:8], cfg_addr_i[1:0]};

  // The ack cycle is decided one edge early so rdata can be registered; the register values
  // that will be current in the ack cycle are exactly the _d values on that edge.
  assign go_ack   = ((state_q == StIdle) && (cfg_wr_i || cfg_rd_i) && (ACK_LAT == 1)) ||
                    ((state_q == StBusy) && (wait_q == 2'd0));
  assign rd_idx   = (state_q == StIdle) ? cfg_addr_i[7:2] : addr_q;
  assign rd_is_wr = (state_q == StIdle) ? cfg_wr_i : wr_q;

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q <= StIdle;
      wait_q  <= 2'd0;
      addr_q  <= 6'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_wr_i || cfg_rd_i) begin
            addr_q  <= cfg_addr_i[7:2];
            wdata_q <= cfg_wdata_i;
            wr_q    <= cfg_wr_i;
            wait_q  <= WaitInit;
            state_q <= (ACK_LAT == 1) ? StAck : StBusy;
          end
        end
        StBusy: begin
          if (wait_q == 2'd0) state_q <= StAck;
          else                wait_q  <= wait_q - 2'd1;
        end
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (go_ack) begin
        ack_q <= 1'b1;
        if (!rd_is_wr) rdata_q <= rd_next;
      end
    end
  end

  assign cfg_ack_o   = ack_q;
  assign cfg_rdata_o = rdata_q;
  assign ctrl_out_o  = ctrl_q;

  assign do_acc   = (state_q == StAck);
  assign do_wr    = do_acc && wr_q;
  assign cnt_clr  = do_wr && (addr_q == AddrCtrl) && wdata_q[1];
  assign cnt_wrap = !cnt_clr && ctrl_q[0] && (&cnt_q);

`ifdef CL_CFG_REG_BANK_TIMER_EN
  logic [31:0] tmr_load_q, tmr_load_d;
  logic [31:0] tmr_cur_q, tmr_cur_d;

  assign tmr_exp = (tmr_cur_q == 32'd1);

  always_comb begin
    tmr_load_d = tmr_load_q;
    tmr_cur_d  = tmr_cur_q;
    if (do_wr && (addr_q == AddrTmrLoad)) begin
      tmr_load_d = wdata_q;
      tmr_cur_d  = wdata_q;
    end else if (tmr_cur_q != 32'd0) begin
      tmr_cur_d = tmr_cur_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      tmr_load_q <= 32'd0;
      tmr_cur_q  <= 32'd0;
    end else begin
      tmr_load_q <= tmr_load_d;
      tmr_cur_q  <= tmr_cur_d;
    end
  end

  assign irq_o = status_q[1] & ctrl_q[2];
`else
  assign tmr_exp = 1'b0;
  assign irq_o   = 1'b0;
`endif

  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    snap_d    = snap_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    if (do_wr && (addr_q == AddrScratch)) scratch_d = wdata_q;
    if (do_wr && (addr_q == AddrCtrl))    ctrl_d    = wdata_q & ~32'h2;
    if (do_wr && (addr_q == AddrStatus))  status_d  = status_q & ~wdata_q[1:0];
    // Set events override a same-cycle W1C.
    status_d = status_d | {tmr_exp, cnt_wrap};
    if (cnt_clr)        cnt_d = 64'd0;
    else if (ctrl_q[0]) cnt_d = cnt_q + 64'd1;
    if (do_acc && !wr_q && (addr_q == AddrCntLo)) snap_d = cnt_q[63:32];
    if (do_acc && (acc_q != 32'hFFFF_FFFF))       acc_d  = acc_q + 32'd1;
  end

  always_comb begin
    rd_next = 32'hDEAD_BEEF;
    case (rd_idx)
      AddrScratch: rd_next = scratch_d;
      AddrCtrl:    rd_next = ctrl_d;
      AddrStatus:  rd_next = {30'd0, status_d};
      AddrCntLo:   rd_next = cnt_d[31:0];
      AddrCntHi:   rd_next = snap_d;
      AddrAccCnt:  rd_next = acc_d;
`ifdef CL_CFG_REG_BANK_TIMER_EN
      AddrTmrLoad: rd_next = tmr_load_d;
      AddrTmrCur:  rd_next = tmr_cur_d;
`endif
      default:     rd_next = 32'hDEAD_BEEF;
    endcase
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      scratch_q <= 32'd0;
      ctrl_q    <= 32'd0;
      status_q  <= 2'd0;
      cnt_q     <= 64'd0;
      snap_q    <= 32'd0;
      acc_q     <= 32'd0;
    end else begin
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_cl_cfg_reg_bank.sv
// Directed bench for cl_cfg_reg_bank: one instance with ACK_LAT=1 and one with ACK_LAT=4.
module tb_cl_cfg_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        wr1 = 1'b0, rd1 = 1'b0, wr4 = 1'b0, rd4 = 1'b0;
  logic        ack1, ack4, irq1, irq4;
  logic [31:0] rdata1, rdata4, ctrl1, ctrl4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cl_cfg_reg_bank #(.ACK_LAT(1)) u_dut1 (
    .clk        (clk),
    .sync_rst_n (rst_n),
    .cfg_addr_i (addr),
    .cfg_wdata_i(wdata),
    .cfg_wr_i   (wr1),
    .cfg_rd_i   (rd1),
    .cfg_ack_o  (ack1),
    .cfg_rdata_o(rdata1),
    .ctrl_out_o (ctrl1),
    .irq_o      (irq1)
  );

  cl_cfg_reg_bank #(.ACK_LAT(4)) u_dut4 (
    .clk        (clk),
    .sync_rst_n (rst_n),
    .cfg_addr_i (addr),
    .cfg_wdata_i(wdata),
    .cfg_wr_i   (wr4),
    .cfg_rd_i   (rd4),
    .cfg_ack_o  (ack4),
    .cfg_rdata_o(rdata4),
    .ctrl_out_o (ctrl4),
    .irq_o      (irq4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one pulse and returns the ack latency (0 = no ack within budget) and rdata.
  task automatic access(input bit sel4, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    addr  = a;
    wdata = d;
    if (sel4) begin wr4 = wr; rd4 = !wr; end
    else      begin wr1 = wr; rd1 = !wr; end
    @(negedge clk);
    {wr1, rd1, wr4, rd4} = 4'b0;
    lat = 0;
    rd  = 32'hxxxx_xxxx;
    for (int i = 1; i <= 12; i++) begin
      if (sel4 ? ack4 : ack1) begin
        lat = i;
        rd  = sel4 ? rdata4 : rdata1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wr_reg(input bit sel4, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
    logic [31:0] rd;
    int          lat;
    access(sel4, 1'b1, a, d, rd, lat);
    check({tag, "_lat"}, lat, sel4 ? 32'd4 : 32'd1);
  endtask

  task automatic rd_reg(input bit sel4, input logic [31:0] a, input logic [31:0] exp,
                        input string tag);
    logic [31:0] rd;
    int          lat;
    access(sel4, 1'b0, a, 32'd0, rd, lat);
    check({tag, "_lat"}, lat, sel4 ? 32'd4 : 32'd1);
    check(tag, rd, exp);
  endtask

  initial begin
    int n_ack;
    repeat (3) @(negedge clk);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_ctrl1", ctrl1, 32'd0);
    check("rst_irq1", {31'd0, irq1}, 32'd0);
    rst_n = 1'b1;

    // Scratch round trip and access count at both latencies.
    for (int s = 0; s < 2; s++) begin
      wr_reg(s[0], 32'h0000_0000, 32'hA5A5_1234, "scr_wr");
      rd_reg(s[0], 32'h0000_0000, 32'hA5A5_1234, "scr_rd");
      rd_reg(s[0], 32'h0000_0014, 32'd2, "acc2");
    end

    // Unmapped offsets, ignored address bits.
    rd_reg(1'b0, 32'h0000_0040, 32'hDEAD_BEEF, "unmap_rd");
    wr_reg(1'b0, 32'h0000_0040, 32'h0000_0001, "unmap_wr");
    rd_reg(1'b0, 32'hFFFF_0001, 32'hA5A5_1234, "scr_alias");
    rd_reg(1'b0, 32'h0000_0014, 32'd6, "acc6");

    // Counter wrap sets sticky STATUS[0]; W1C clears it.
    @(negedge clk);
    force u_dut1.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    release u_dut1.cnt_q;
    wr_reg(1'b0, 32'h0000_0004, 32'h0000_0001, "ctrl_en");
    check("ctrl_out_ack", ctrl1, 32'd0);
    @(negedge clk);
    check("ctrl_out_next", ctrl1, 32'd1);
    repeat (3) @(negedge clk);
    rd_reg(1'b0, 32'h0000_0008, 32'd1, "wrap_sts");
    wr_reg(1'b0, 32'h0000_0008, 32'd1, "w1c_wr");
    rd_reg(1'b0, 32'h0000_0008, 32'd0, "w1c_sts");
    wr_reg(1'b0, 32'h0000_0004, 32'h0000_0002, "cnt_clr");
    rd_reg(1'b0, 32'h0000_0004, 32'd0, "clr_ctrl");
    rd_reg(1'b0, 32'h0000_000C, 32'd0, "clr_cnt");

    // CNT_HI returns the snapshot taken at the CNT_LO read, not the live value.
    @(negedge clk);
    force u_dut1.cnt_q = 64'h0000_0007_1234_5678;
    @(negedge clk);
    release u_dut1.cnt_q;
    rd_reg(1'b0, 32'h0000_000C, 32'h1234_5678, "cnt_lo");
    @(negedge clk);
    force u_dut1.cnt_q = 64'h0000_0009_0000_0000;
    @(negedge clk);
    release u_dut1.cnt_q;
    rd_reg(1'b0, 32'h0000_0010, 32'h0000_0007, "cnt_hi_snap");

`ifdef CL_CFG_REG_BANK_TIMER_EN
    wr_reg(1'b0, 32'h0000_0004, 32'h0000_0004, "irq_en");
    wr_reg(1'b0, 32'h0000_0018, 32'd5, "tmr_load");
    rd_reg(1'b0, 32'h0000_001C, 32'd4, "tmr_cur4");
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("tmr_irq_k%0d", k), {31'd0, irq1}, {31'd0, k == 4});
    end
    rd_reg(1'b0, 32'h0000_001C, 32'd0, "tmr_cur0");
    rd_reg(1'b0, 32'h0000_0018, 32'd5, "tmr_load_rb");
    rd_reg(1'b0, 32'h0000_0008, 32'd2, "tmr_sts");
    wr_reg(1'b0, 32'h0000_0008, 32'd2, "tmr_w1c");
    check("irq_at_ack", {31'd0, irq1}, 32'd1);
    @(negedge clk);
    check("irq_dropped", {31'd0, irq1}, 32'd0);
`else
    wr_reg(1'b0, 32'h0000_0004, 32'h0000_0004, "irq_en");
    wr_reg(1'b0, 32'h0000_0018, 32'd5, "tmr_load");
    rd_reg(1'b0, 32'h0000_0018, 32'hDEAD_BEEF, "tmr_load_na");
    rd_reg(1'b0, 32'h0000_001C, 32'hDEAD_BEEF, "tmr_cur_na");
    repeat (8) @(negedge clk);
    rd_reg(1'b0, 32'h0000_0008, 32'd0, "tmr_sts_na");
    check("irq_tied", {31'd0, irq1}, 32'd0);
`endif

    // Reset during BUSY on the ACK_LAT=4 instance abandons the access.
    @(negedge clk);
    addr  = 32'h0000_0000;
    wdata = 32'h0000_1111;
    wr4   = 1'b1;
    @(negedge clk);
    wr4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack4) n_ack++;
      @(negedge clk);
    end
    check("rst_no_ack", n_ack, 32'd0);
    rd_reg(1'b1, 32'h0000_0014, 32'd0, "rst_acc");
    rd_reg(1'b1, 32'h0000_0000, 32'd0, "rst_scr");
    rd_reg(1'b1, 32'h0000_0004, 32'd0, "rst_ctrl");
    rd_reg(1'b1, 32'h0000_0008, 32'd0, "rst_sts");
    rd_reg(1'b1, 32'h0000_000C, 32'd0, "rst_cnt_lo");
    rd_reg(1'b1, 32'h0000_0010, 32'd0, "rst_cnt_hi");
    rd_reg(1'b1, 32'h0000_003C, 32'hDEAD_BEEF, "rst_unmap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cl_cfg_reg_bank.md
# cl_cfg_reg_bank

Register-bank slave that terminates one `cfg_bus_t` port of the OCL slave decoder. It sits directly downstream of the decoder's per-slave 64 KB windows, addressed by `addr[31:16]`, and consumes the one-cycle `wr`/`rd` pulses. It returns a one-cycle `ack` with `rdata` after a fixed latency. It holds:
- scratch and control registers
- a 64-bit cycle counter with coherent snapshot read
- an access counter
- sticky W1C status
- an optional countdown timer with interrupt

## Interface
- `ACK_LAT`, default 1: cycles from `cfg_wr`/`cfg_rd` pulse to `cfg_ack`; legal 1..4.
- `clk`  in  1  clock.
- `sync_rst_n`  in  1  reset; asynchronous, active-low.
- `cfg_addr`  in  32  byte address; only `[7:2]` decoded, `[1:0]` and `[31:8]` ignored.
- `cfg_wdata`  in  32  write data, valid with `cfg_wr`.
- `cfg_wr`  in  1  one-cycle write pulse.
- `cfg_rd`  in  1  one-cycle read pulse.
- `cfg_ack`  out  1  one-cycle completion pulse.
- `cfg_rdata`  out  32  read data; valid in the `cfg_ack` cycle, held until the next ack.
- `ctrl_out`  out  32  current CTRL register value.
- `irq`  out  1  level interrupt: `STATUS[1] & CTRL[2]`; constant 0 without the timer.

## Operation
Register map by byte offset, `cfg_addr[7:0]`:
- 0x00 SCRATCH: RW.
- 0x04 CTRL: RW.
  - bit0 cnt_en.
  - bit1 cnt_clr: self-clearing, always reads 0.
  - bit2 irq_en.
  - bits[31:3] RW, no function.
- 0x08 STATUS: W1C.
  - bit0 cnt_wrap: sticky.
  - bit1 tmr_expired: sticky.
  - other bits read 0.
- 0x0C CNT_LO: RO; a read also copies `cnt[63:32]` into the snapshot register.
- 0x10 CNT_HI: RO; returns the snapshot, not the live count.
- 0x14 ACC_CNT: RO; count of completed accesses (reads and writes), saturating at 0xFFFF_FFFF.
- 0x18 TMR_LOAD: RW.
- 0x1C TMR_CUR: RO.
- Any other offset: reads 0xDEAD_BEEF, writes ignored, still acked.

Handshake FSM:
- IDLE: a `cfg_wr` or `cfg_rd` pulse latches addr, wdata and direction, then goes to BUSY.
  - `cfg_wr` and `cfg_rd` together are treated as a write.
- BUSY: wait count = `ACK_LAT-1`, then go to ACK.
- ACK: assert `cfg_ack` for one cycle, update `cfg_rdata` on reads, increment ACC_CNT, return to IDLE.
- Pulses arriving in BUSY or ACK are dropped with no ack; upstream never issues them.
- Register write and read sampling both take effect in the ACK cycle.

Cycle counter `cnt[63:0]`:
- cnt_clr has priority and zeroes the counter.
- Otherwise, with cnt_en set, the counter increments by 1 each cycle.
- Wrap from all-ones to 0 sets `STATUS[0]`.

Status updates:
- A set event and a W1C of the same bit in the same cycle: set wins.
- ACC_CNT increments even for unmapped offsets.

## Timing
- Reset values:
  - all registers, counters and the snapshot = 0
  - FSM in IDLE
  - `cfg_ack` = 0, `cfg_rdata` = 0, `ctrl_out` = 0, `irq` = 0
- Latency: a pulse in cycle N gives `cfg_ack` in cycle N+`ACK_LAT`.
  - Back-to-back throughput: one access per `ACK_LAT`+1 cycles.
- The CNT_LO read value is the count at the ACK cycle. The snapshot is loaded in the same cycle.
- `ctrl_out` and `irq` are registered; they reflect a write one cycle after its ack.
- Reset mid-access: the access is abandoned and no ack is issued after release.

## Configuration
- `CL_CFG_REG_BANK_TIMER_EN` defined: TMR_LOAD/TMR_CUR are implemented.
  - Writing TMR_LOAD loads TMR_CUR in the ACK cycle.
  - TMR_CUR decrements by 1 per cycle while nonzero.
  - The 1→0 transition sets `STATUS[1]`.
  - Writing TMR_LOAD = 0 stops the timer without setting `STATUS[1]`.
  - A load that coincides with the 1→0 transition: the load wins and `STATUS[1]` is set.
- Undefined: 0x18 and 0x1C read 0xDEAD_BEEF and ignore writes; `STATUS[1]` reads 0; `irq` is tied to 0.

## Test plan
- Write SCRATCH = 0xA5A5_1234, then read it back (`ACK_LAT`=1 and 4) -> ack exactly 1 and 4 cycles after each pulse; rdata 0xA5A5_1234; ACC_CNT = 2.
- Read offset 0x40, then write 0x40 = 0x1 -> each acked; rdata 0xDEAD_BEEF; no register changes; ACC_CNT increments by 2.
- Counter wrap and W1C:
  - Force the counter to 0xFFFF_FFFF_FFFF_FFFE and set CTRL = 0x1 -> STATUS reads 0x1 after the wrap.
  - Write STATUS = 0x1 -> STATUS reads 0.
  - Read CNT_LO then CNT_HI -> CNT_HI equals the count at the CNT_LO ack, not the live value.
- Timer (macro defined): CTRL = 0x4, TMR_LOAD = 5 -> TMR_CUR counts 5..0; `STATUS[1]` and `irq` rise on expiry; write STATUS = 0x2 -> `irq` drops one cycle after the ack.
- Assert `sync_rst_n` during BUSY with `ACK_LAT`=4 -> no ack after release; all reads return 0 except unmapped offsets (0xDEAD_BEEF).
